axi_gp_reg_slave: RTL

- AXI4 (full, burst-capable) slave register file that terminates the processing system's general-purpose master port inside the role.
- Exposes REG_NUM 32-bit control registers to role logic, plus a per-register write pulse.
- Serves as the responder end of the PS GP master link; instantiated once in the role top.

---
 rtl/axi_gp_reg_pkg.sv | 23 ++
 rtl/axi_gp_reg_addr_gen.sv | 82 ++++++++
 rtl/axi_gp_reg_slave.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_gp_reg_pkg.sv
// Shared constants and FSM state types for the AXI GP register slave.
// Contents: AXI response codes, burst type codes, write/read FSM state enums.
package axi_gp_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    StWIdle,
    StWData,
    StWResp
  } w_state_e;

  typedef enum logic {
    StRIdle,
    StRData
  } r_state_e;

endpackage

// File: rtl/axi_gp_reg_addr_gen.sv
// Burst address / beat counter for one AXI channel.
// Ports:
//   clk, rst              clock, async active-high reset
//   load                  capture start_* (beat 0 becomes the current beat)
//   step                  consume the current beat and advance to the next
//   start_addr/len/burst  word address (addr[ADDR_WIDTH-1:2]), AxLEN, AxBURST
//   idx                   register index of the current beat
//   beat_err              current beat is out of range or uses WRAP/reserved burst
//   beat_last             current beat is the counted final beat
// The current beat is taken from start_* while load is high, so a caller can
// consume beat 0 in the same cycle the request is accepted (load && step).
module axi_gp_reg_addr_gen
  import axi_gp_reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_NUM    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       step,
  input  logic [ADDR_WIDTH-3:0]      start_addr,
  input  logic [7:0]                 start_len,
  input  logic [1:0]                 start_burst,
  output logic [$clog2(REG_NUM)-1:0] idx,
  output logic                       beat_err,
  output logic                       beat_last
);

  localparam int unsigned IdxW  = $clog2(REG_NUM);
  localparam int unsigned WordW = ADDR_WIDTH - 2;

  logic [WordW-1:0] addr_q, addr_d, cur_addr;
  logic [7:0]       cnt_q, cnt_d, cur_cnt;
  logic [7:0]       len_q, len_d, cur_len;
  logic [1:0]       burst_q, burst_d, cur_burst;

  always_comb begin
    cur_addr  = load ? start_addr  : addr_q;
    cur_cnt   = load ? 8'd0        : cnt_q;
    cur_len   = load ? start_len   : len_q;
    cur_burst = load ? start_burst : burst_q;

    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    burst_d = burst_q;
    if (load || step) begin
      len_d   = cur_len;
      burst_d = cur_burst;
      addr_d  = cur_addr;
      cnt_d   = cur_cnt;
      if (step) begin
        cnt_d = cur_cnt + 8'd1;
        if (cur_burst == BURST_INCR) begin
          addr_d = cur_addr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      burst_q <= BURST_FIXED;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      burst_q <= burst_d;
    end
  end

  // REG_NUM is a power of two, so any set bit above the index field is out of range.
  assign idx       = cur_addr[IdxW-1:0];
  assign beat_err  = (cur_burst == BURST_WRAP) || (cur_burst == 2'b11) ||
                     (|cur_addr[WordW-1:IdxW]);
  assign beat_last = (cur_cnt == cur_len);

endmodule

// File: rtl/axi_gp_reg_slave.sv
// AXI4 burst-capable slave register file terminating the PS GP master port.
// Ports:
//   clk, rst          single clock, async active-high reset
//   s_axi_aw*/w*/b*   AXI write address / data / response channels
//   s_axi_ar*/r*      AXI read address / data channels
//   reg_out           register contents, register i at [32i+31:32i]
//   reg_wr_pulse      one-cycle pulse per register written with non-zero strobe
//   reg_ro_in         (AXI_GP_REG_RO_EN only) live values for upper-half registers
// Build option: define AXI_GP_REG_RO_EN to make registers REG_NUM/2..REG_NUM-1
// read-only views of reg_ro_in; writes to them are discarded with SLVERR.
module axi_gp_reg_slave
  import axi_gp_reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned REG_NUM    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [REG_NUM*32-1:0]   reg_out,
  output logic [REG_NUM-1:0]      reg_wr_pulse
`ifdef AXI_GP_REG_RO_EN
  ,
  input  logic [REG_NUM/2*32-1:0] reg_ro_in
`endif
);

  localparam int unsigned IdxW = $clog2(REG_NUM);

  // ---------------- Write channel ----------------
  w_state_e                   w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]        bid_q, bid_d;
  logic                       werr_q, werr_d;
  logic [REG_NUM-1:0][31:0]   reg_q, reg_d;
  logic [REG_NUM-1:0]         pulse_q, pulse_d;
  logic                       aw_hs, w_hs;
  logic [IdxW-1:0]            w_idx;
  logic                       w_beat_err, w_last, w_err;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

  axi_gp_reg_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .REG_NUM   (REG_NUM)
  ) u_wr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (aw_hs),
    .step       (w_hs),
    .start_addr (s_axi_awaddr[ADDR_WIDTH-1:2]),
    .start_len  (s_axi_awlen),
    .start_burst(s_axi_awburst),
    .idx        (w_idx),
    .beat_err   (w_beat_err),
    .beat_last  (w_last)
  );

`ifdef AXI_GP_REG_RO_EN
  assign w_err = w_beat_err || w_idx[IdxW-1];
`else
  assign w_err = w_beat_err;
`endif

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    werr_d    = werr_q;
    reg_d     = reg_q;
    pulse_d   = '0;
    unique case (w_state_q)
      StWIdle: begin
        if (s_axi_awvalid) begin
          w_state_d = StWData;
          bid_d     = s_axi_awid;
          werr_d    = 1'b0;
        end
      end
      StWData: begin
        if (s_axi_wvalid) begin
          if (w_err) begin
            werr_d = 1'b1;
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (s_axi_wstrb[b]) reg_d[w_idx][8*b +: 8] = s_axi_wdata[8*b +: 8];
            end
            if (|s_axi_wstrb) pulse_d[w_idx] = 1'b1;
          end
          // The beat counter, not wlast, ends the burst; disagreement is an error.
          if (s_axi_wlast != w_last) werr_d = 1'b1;
          if (w_last) w_state_d = StWResp;
        end
      end
      StWResp: begin
        if (s_axi_bready) w_state_d = StWIdle;
      end
      default: w_state_d = StWIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= StWIdle;
      bid_q     <= '0;
      werr_q    <= 1'b0;
      reg_q     <= '0;
      pulse_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      werr_q    <= werr_d;
      reg_q     <= reg_d;
      pulse_q   <= pulse_d;
    end
  end

  assign s_axi_awready = (w_state_q == StWIdle);
  assign s_axi_wready  = (w_state_q == StWData);
  assign s_axi_bvalid  = (w_state_q == StWResp);
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = (s_axi_bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;
  assign reg_out       = reg_q;
  assign reg_wr_pulse  = pulse_q;

  // ---------------- Read channel ----------------
  r_state_e                 r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]      rid_q, rid_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic                     rlast_q, rlast_d;
  logic                     ar_hs, r_hs, rd_load;
  logic [IdxW-1:0]          r_idx;
  logic                     r_err, r_last;
  logic [REG_NUM-1:0][31:0] rd_words;

  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign r_hs    = s_axi_rvalid && s_axi_rready;
  // A beat is loaded on the AR handshake and after every non-final R handshake.
  assign rd_load = ar_hs || (r_hs && !rlast_q);

  axi_gp_reg_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .REG_NUM   (REG_NUM)
  ) u_rd_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (ar_hs),
    .step       (rd_load),
    .start_addr (s_axi_araddr[ADDR_WIDTH-1:2]),
    .start_len  (s_axi_arlen),
    .start_burst(s_axi_arburst),
    .idx        (r_idx),
    .beat_err   (r_err),
    .beat_last  (r_last)
  );

`ifdef AXI_GP_REG_RO_EN
  always_comb begin
    rd_words = reg_q;
    for (int i = REG_NUM / 2; i < REG_NUM; i++) begin
      rd_words[i] = reg_ro_in[(i - REG_NUM / 2) * 32 +: 32];
    end
  end
`else
  assign rd_words = reg_q;
`endif

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    unique case (r_state_q)
      StRIdle: begin
        if (s_axi_arvalid) begin
          r_state_d = StRData;
          rid_d     = s_axi_arid;
        end
      end
      StRData: begin
        if (s_axi_rready && rlast_q) begin
          r_state_d = StRIdle;
          rlast_d   = 1'b0;
        end
      end
      default: r_state_d = StRIdle;
    endcase
    // Sampling reg_q (not reg_d) gives the old value on a same-cycle write.
    if (rd_load) begin
      rdata_d = r_err ? '0 : rd_words[r_idx];
      rresp_d = r_err ? RESP_SLVERR : RESP_OKAY;
      rlast_d = r_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= StRIdle;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign s_axi_arready = (r_state_q == StRIdle);
  assign s_axi_rvalid  = (r_state_q == StRData);
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule
